// File: rtl/input_debouncer_pkg.sv
// ============================================================================
// Module      : debounce_pkg
// Description : Shared debouncer FSM state encoding and default widths.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

   localparam int c_GLITCH_W = 8;

   // Bit 1 of the encoding tracks the accepted output level.
   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      PEND_HI   = 2'b01,
      STABLE_HI = 2'b11,
      PEND_LO   = 2'b10
   } deb_state_t;

endpackage

`default_nettype wire

// File: rtl/input_debouncer_if.sv
// ============================================================================
// Module      : input_debouncer_if
// Description : Signal bundle between a debouncer and its user.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface input_debouncer_if
   import debounce_pkg::*;
#(
   parameter int GLITCH_W = c_GLITCH_W
) ();

   logic                in_sig;
   logic                glitch_clr;
   logic                sig_out;
   logic                busy;
   logic [GLITCH_W-1:0] glitch_cnt;

   modport master (
      output in_sig,
      output glitch_clr,
      input  sig_out,
      input  busy,
      input  glitch_cnt
   );

   modport slave (
      input  in_sig,
      input  glitch_clr,
      output sig_out,
      output busy,
      output glitch_cnt
   );

endinterface

`default_nettype wire

// File: rtl/input_debouncer_sync_chain.sv
// ============================================================================
// Module      : sync_chain
// Description : Multi-flop synchronizer for a single asynchronous bit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_chain #(
   parameter int STAGES = 2
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic d,
   output logic      q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
// Module      : input_debouncer
// Description : Synchronizes and debounces a bouncy input; counts aborts.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int GLITCH_W        = c_GLITCH_W
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input_debouncer_if.slave  dbus
);

   localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                w_sync_sig;
   deb_state_t          r_state;
   deb_state_t          w_state_nxt;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_CNT_W-1:0]  w_cnt_nxt;
   logic                w_abort;
   logic                r_sig_out;
   logic                w_busy;
   logic [GLITCH_W-1:0] r_glitch_cnt;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (dbus.in_sig),
      .q   (w_sync_sig)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= STABLE_LO;
         r_cnt     <= '0;
         r_sig_out <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_sig_out <= (w_state_nxt == STABLE_HI) || (w_state_nxt == PEND_LO);
      end
   end

   // Counter restarts at zero on every state change except entry into a PEND state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_abort     = 1'b0;
      case (r_state)
         STABLE_LO: begin
            if (w_sync_sig) begin
               w_state_nxt = PEND_HI;
               w_cnt_nxt   = c_CNT_ONE;
            end
         end
         PEND_HI: begin
            if (!w_sync_sig) begin
               w_state_nxt = STABLE_LO;
               w_abort     = 1'b1;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = STABLE_HI;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!w_sync_sig) begin
               w_state_nxt = PEND_LO;
               w_cnt_nxt   = c_CNT_ONE;
            end
         end
         PEND_LO: begin
            if (w_sync_sig) begin
               w_state_nxt = STABLE_HI;
               w_abort     = 1'b1;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = STABLE_LO;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = STABLE_LO;
         end
      endcase
   end

   always_comb begin
      w_busy = (r_state == PEND_HI) || (r_state == PEND_LO);
   end

   // Clear takes priority over a coincident abort.
   always_ff @(posedge clk) begin
      if (rst || dbus.glitch_clr) begin
         r_glitch_cnt <= '0;
      end else if (w_abort && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
         r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
      end
   end

   assign dbus.sig_out    = r_sig_out;
   assign dbus.busy       = w_busy;
   assign dbus.glitch_cnt = r_glitch_cnt;

endmodule

`default_nettype wire
